// File: rtl/rgb_block_tracker.sv
// Per-frame colour tracker for an RGB888 active-video stream: reports the bounding box,
// matched-pixel count, found flag and line-length error of pixels near a target colour.
module rgb_block_tracker #(
    parameter int          H_DISP       = 1920,
    parameter int          V_DISP       = 1080,
    parameter logic [23:0] TARGET_COLOR = 24'hffc0cb,
    parameter int          COLOR_TOL    = 8,
    parameter int          MIN_PIXELS   = 16
) (
    input  logic        pixel_clk,
    input  logic        sys_rst,
    input  logic        vs_in,
    input  logic        de_in,
    input  logic [23:0] rgb_in,
    output logic [10:0] blk_x_min,
    output logic [10:0] blk_x_max,
    output logic [10:0] blk_y_min,
    output logic [10:0] blk_y_max,
    output logic [21:0] pix_count,
    output logic        blk_found,
    output logic        fmt_err,
    output logic        frame_done
);

    localparam logic [10:0] H_MAX   = 11'(H_DISP);
    localparam logic [10:0] V_LAST  = 11'(V_DISP - 1);
    localparam logic [8:0]  TOL     = 9'(COLOR_TOL);
    localparam logic [21:0] MIN_CNT = 22'(MIN_PIXELS);

    typedef enum logic [1:0] {WAIT_VS, ACTIVE, DRAIN, REPORT} state_t;

    state_t      state_q, state_d;
    logic        vs_q, vs_d, vs_prev_q, vs_prev_d;
    logic        de_q, de_d, de_prev_q, de_prev_d;
    logic [23:0] rgb_q, rgb_d;
    logic [10:0] x_cnt_q, x_cnt_d, y_cnt_q, y_cnt_d;
    logic        err_q, err_d;
    logic        drain_q, drain_d;
    logic        s1_match_q, s1_match_d;
    logic [10:0] s1_x_q, s1_x_d, s1_y_q, s1_y_d;
    logic [21:0] acc_cnt_q, acc_cnt_d;
    logic [10:0] acc_xmin_q, acc_xmin_d, acc_xmax_q, acc_xmax_d;
    logic [10:0] acc_ymin_q, acc_ymin_d, acc_ymax_q, acc_ymax_d;
    logic [10:0] blk_x_min_q, blk_x_min_d, blk_x_max_q, blk_x_max_d;
    logic [10:0] blk_y_min_q, blk_y_min_d, blk_y_max_q, blk_y_max_d;
    logic [21:0] pix_count_q, pix_count_d;
    logic        blk_found_q, blk_found_d, fmt_err_q, fmt_err_d;
    logic        frame_done_q, frame_done_d;

    logic        vs_rise, de_fall, acc_clear, found_now;
    logic [2:0]  chan_ok;

    assign vs_rise = vs_q & ~vs_prev_q;
    assign de_fall = de_prev_q & ~de_q;

    // Unsigned 9-bit distance per channel so a dark pixel can never wrap into tolerance.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_chan
            logic [8:0] pix_c, tgt_c, diff;
            assign pix_c       = {1'b0, rgb_q[gi*8 +: 8]};
            assign tgt_c       = {1'b0, TARGET_COLOR[gi*8 +: 8]};
            assign diff        = (pix_c >= tgt_c) ? (pix_c - tgt_c) : (tgt_c - pix_c);
            assign chan_ok[gi] = (diff <= TOL);
        end
    endgenerate

    always_comb begin
        vs_d         = vs_in;
        de_d         = de_in;
        rgb_d        = rgb_in;
        vs_prev_d    = vs_q;
        de_prev_d    = de_q;
        state_d      = state_q;
        x_cnt_d      = x_cnt_q;
        y_cnt_d      = y_cnt_q;
        err_d        = err_q;
        drain_d      = drain_q;
        s1_match_d   = 1'b0;
        s1_x_d       = x_cnt_q;
        s1_y_d       = y_cnt_q;
        acc_cnt_d    = acc_cnt_q;
        acc_xmin_d   = acc_xmin_q;
        acc_xmax_d   = acc_xmax_q;
        acc_ymin_d   = acc_ymin_q;
        acc_ymax_d   = acc_ymax_q;
        blk_x_min_d  = blk_x_min_q;
        blk_x_max_d  = blk_x_max_q;
        blk_y_min_d  = blk_y_min_q;
        blk_y_max_d  = blk_y_max_q;
        pix_count_d  = pix_count_q;
        blk_found_d  = blk_found_q;
        fmt_err_d    = fmt_err_q;
        frame_done_d = 1'b0;
        acc_clear    = 1'b0;
        found_now    = (acc_cnt_q >= MIN_CNT);

        if (s1_match_q) begin
            acc_cnt_d = acc_cnt_q + 22'd1;
            if (acc_cnt_q == 22'd0) begin
                acc_xmin_d = s1_x_q;
                acc_xmax_d = s1_x_q;
                acc_ymin_d = s1_y_q;
                acc_ymax_d = s1_y_q;
            end else begin
                if (s1_x_q < acc_xmin_q) acc_xmin_d = s1_x_q;
                if (s1_x_q > acc_xmax_q) acc_xmax_d = s1_x_q;
                if (s1_y_q < acc_ymin_q) acc_ymin_d = s1_y_q;
                if (s1_y_q > acc_ymax_q) acc_ymax_d = s1_y_q;
            end
        end

        case (state_q)
            WAIT_VS: begin
                if (vs_rise) begin
                    state_d   = ACTIVE;
                    x_cnt_d   = 11'd0;
                    y_cnt_d   = 11'd0;
                    err_d     = 1'b0;
                    acc_clear = 1'b1;
                end
            end
            ACTIVE: begin
                if (vs_rise) begin
                    // Short frame: start over, previously reported outputs stay put.
                    x_cnt_d   = 11'd0;
                    y_cnt_d   = 11'd0;
                    err_d     = 1'b0;
                    acc_clear = 1'b1;
                end else begin
                    s1_match_d = de_q & (&chan_ok) & (x_cnt_q < H_MAX);
                    if (de_q) begin
                        if (x_cnt_q == H_MAX) err_d = 1'b1;
                        else                  x_cnt_d = x_cnt_q + 11'd1;
                    end
                    if (de_fall) begin
                        if (x_cnt_q != H_MAX) err_d = 1'b1;
                        x_cnt_d = 11'd0;
                        y_cnt_d = y_cnt_q + 11'd1;
                        if (y_cnt_q == V_LAST) begin
                            state_d = DRAIN;
                            drain_d = 1'b0;
                        end
                    end
                end
            end
            DRAIN: begin
                drain_d = drain_q + 1'b1;
                if (drain_q) state_d = REPORT;
            end
            REPORT: begin
                blk_found_d  = found_now;
                pix_count_d  = acc_cnt_q;
                fmt_err_d    = err_q;
                blk_x_min_d  = found_now ? acc_xmin_q : 11'd0;
                blk_x_max_d  = found_now ? acc_xmax_q : 11'd0;
                blk_y_min_d  = found_now ? acc_ymin_q : 11'd0;
                blk_y_max_d  = found_now ? acc_ymax_q : 11'd0;
                frame_done_d = 1'b1;
                state_d      = WAIT_VS;
            end
            default: state_d = WAIT_VS;
        endcase

        if (acc_clear) begin
            acc_cnt_d  = 22'd0;
            acc_xmin_d = '1;
            acc_xmax_d = '0;
            acc_ymin_d = '1;
            acc_ymax_d = '0;
        end
    end

    always_ff @(posedge pixel_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q      <= WAIT_VS;
            vs_q         <= 1'b0;
            de_q         <= 1'b0;
            rgb_q        <= '0;
            vs_prev_q    <= 1'b0;
            de_prev_q    <= 1'b0;
            x_cnt_q      <= '0;
            y_cnt_q      <= '0;
            err_q        <= 1'b0;
            drain_q      <= 1'b0;
            s1_match_q   <= 1'b0;
            s1_x_q       <= '0;
            s1_y_q       <= '0;
            acc_cnt_q    <= '0;
            acc_xmin_q   <= '1;
            acc_xmax_q   <= '0;
            acc_ymin_q   <= '1;
            acc_ymax_q   <= '0;
            blk_x_min_q  <= '0;
            blk_x_max_q  <= '0;
            blk_y_min_q  <= '0;
            blk_y_max_q  <= '0;
            pix_count_q  <= '0;
            blk_found_q  <= 1'b0;
            fmt_err_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            vs_q         <= vs_d;
            de_q         <= de_d;
            rgb_q        <= rgb_d;
            vs_prev_q    <= vs_prev_d;
            de_prev_q    <= de_prev_d;
            x_cnt_q      <= x_cnt_d;
            y_cnt_q      <= y_cnt_d;
            err_q        <= err_d;
            drain_q      <= drain_d;
            s1_match_q   <= s1_match_d;
            s1_x_q       <= s1_x_d;
            s1_y_q       <= s1_y_d;
            acc_cnt_q    <= acc_cnt_d;
            acc_xmin_q   <= acc_xmin_d;
            acc_xmax_q   <= acc_xmax_d;
            acc_ymin_q   <= acc_ymin_d;
            acc_ymax_q   <= acc_ymax_d;
            blk_x_min_q  <= blk_x_min_d;
            blk_x_max_q  <= blk_x_max_d;
            blk_y_min_q  <= blk_y_min_d;
            blk_y_max_q  <= blk_y_max_d;
            pix_count_q  <= pix_count_d;
            blk_found_q  <= blk_found_d;
            fmt_err_q    <= fmt_err_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign blk_x_min  = blk_x_min_q;
    assign blk_x_max  = blk_x_max_q;
    assign blk_y_min  = blk_y_min_q;
    assign blk_y_max  = blk_y_max_q;
    assign pix_count  = pix_count_q;
    assign blk_found  = blk_found_q;
    assign fmt_err    = fmt_err_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_rgb_block_tracker.sv
// Scoreboard bench for rgb_block_tracker: each full frame pushes its expected report,
// and every frame_done snapshot is popped and compared in the owning test task.
module tb_rgb_block_tracker;

    localparam int          H = 64;
    localparam int          V = 48;
    localparam logic [23:0] WHITE = 24'hffffff;
    localparam logic [23:0] PINK  = 24'hffc0cb;

    typedef struct packed {
        logic [10:0] xmin;
        logic [10:0] xmax;
        logic [10:0] ymin;
        logic [10:0] ymax;
        logic [21:0] cnt;
        logic        found;
        logic        err;
    } rep_t;

    logic        clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        vs_in = 1'b0;
    logic        de_in = 1'b0;
    logic [23:0] rgb_in = '0;
    logic [10:0] blk_x_min, blk_x_max, blk_y_min, blk_y_max;
    logic [21:0] pix_count;
    logic        blk_found, fmt_err, frame_done;

    int   checks = 0;
    int   failures = 0;
    int   done_cnt = 0;
    rep_t exp_q[$];
    rep_t got_q[$];
    rep_t cur;
    rep_t last_exp;

    rgb_block_tracker #(.H_DISP(H), .V_DISP(V)) dut (
        .pixel_clk (clk),
        .sys_rst   (sys_rst),
        .vs_in     (vs_in),
        .de_in     (de_in),
        .rgb_in    (rgb_in),
        .blk_x_min (blk_x_min),
        .blk_x_max (blk_x_max),
        .blk_y_min (blk_y_min),
        .blk_y_max (blk_y_max),
        .pix_count (pix_count),
        .blk_found (blk_found),
        .fmt_err   (fmt_err),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    assign cur = {blk_x_min, blk_x_max, blk_y_min, blk_y_max, pix_count, blk_found, fmt_err};

    always @(negedge clk) begin
        if (frame_done) begin
            got_q.push_back(cur);
            done_cnt <= done_cnt + 1;
        end
    end

    function automatic bit in_tol(input logic [23:0] c);
        bit ok = 1'b1;
        for (int k = 0; k < 3; k++) begin
            int d = int'(c[k*8 +: 8]) - int'(PINK[k*8 +: 8]);
            if (d < 0) d = -d;
            if (d > 8) ok = 1'b0;
        end
        return ok;
    endfunction

    function automatic rep_t model(input int x0, input int y0, input int w, input int h,
                                   input logic [23:0] col, input bit err);
        rep_t r;
        int   n = in_tol(col) ? w * h : 0;
        r = '0;
        r.cnt   = 22'(n);
        r.found = (n >= 16);
        r.err   = err;
        if (r.found) begin
            r.xmin = 11'(x0);
            r.xmax = 11'(x0 + w - 1);
            r.ymin = 11'(y0);
            r.ymax = 11'(y0 + h - 1);
        end
        return r;
    endfunction

    function automatic string fmt(input rep_t r);
        return $sformatf("x=%0d..%0d y=%0d..%0d cnt=%0d found=%0d err=%0d",
                         r.xmin, r.xmax, r.ymin, r.ymax, r.cnt, r.found, r.err);
    endfunction

    task automatic drive(input logic v, input logic d, input logic [23:0] c);
        @(negedge clk);
        vs_in  = v;
        de_in  = d;
        rgb_in = c;
    endtask

    // stop_after >= 0 ends the frame right after that line, leaving it unfinished.
    task automatic send_frame(input int x0, input int y0, input int w, input int h,
                              input logic [23:0] col, input int short_line, input int stop_after);
        repeat (2) drive(1'b1, 1'b0, '0);
        repeat (3) drive(1'b0, 1'b0, '0);
        for (int y = 0; y < V; y++) begin
            int len = (y == short_line) ? H - 1 : H;
            for (int x = 0; x < len; x++) begin
                bit inb = (x >= x0) && (x < x0 + w) && (y >= y0) && (y < y0 + h);
                drive(1'b0, 1'b1, inb ? col : WHITE);
            end
            repeat (3) drive(1'b0, 1'b0, '0);
            if (y == stop_after) return;
        end
        repeat (2) drive(1'b0, 1'b0, '0);
    endtask

    task automatic wait_report(output bit timed_out);
        int n = 0;
        while (got_q.size() == 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        timed_out = (got_q.size() == 0);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++;
        if (cur !== rep_t'(0)) begin
            failures++;
            $display("FAIL reset_outputs got %s required all zero", fmt(cur));
        end
        checks++;
        if (frame_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_done got %b required 0", frame_done);
        end
        sys_rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (cur !== rep_t'(0) || frame_done !== 1'b0) begin
            failures++;
            $display("FAIL post_reset got %s done=%b required all zero", fmt(cur), frame_done);
        end
        $display("reset: %s", fmt(cur));
    endtask

    // Table rows: x0, y0, w, h, colour, short line; one report compared per row.
    task automatic test_frames(input string name, input int rows,
                               input int tx0[4], input int ty0[4], input int tw[4], input int th[4],
                               input logic [23:0] tcol[4], input int tshort[4]);
        for (int i = 0; i < rows; i++) begin
            rep_t e, got;
            bit   to;
            e = model(tx0[i], ty0[i], tw[i], th[i], tcol[i], tshort[i] >= 0);
            exp_q.push_back(e);
            send_frame(tx0[i], ty0[i], tw[i], th[i], tcol[i], tshort[i], -1);
            wait_report(to);
            e = exp_q.pop_front();
            checks++;
            if (to) begin
                failures++;
                $display("FAIL %s_%0d no frame_done, required report %s", name, i, fmt(e));
            end else begin
                got = got_q.pop_front();
                if (got !== e) begin
                    failures++;
                    $display("FAIL %s_%0d got %s required %s", name, i, fmt(got), fmt(e));
                end else begin
                    $display("%s_%0d report %s", name, i, fmt(got));
                end
            end
            last_exp = e;
        end
    endtask

    task automatic test_short_frame;
        int   d0;
        rep_t e, got;
        bit   to;
        d0 = done_cnt;
        send_frame(50, 5, 8, 8, PINK, -1, 30);
        repeat (10) @(negedge clk);
        checks++;
        if (cur !== last_exp) begin
            failures++;
            $display("FAIL short_outputs got %s required %s", fmt(cur), fmt(last_exp));
        end
        checks++;
        if (done_cnt != d0 || got_q.size() != 0) begin
            failures++;
            $display("FAIL short_done got %0d pulses required 0", done_cnt - d0);
            got_q.delete();
        end
        $display("short_frame outputs %s", fmt(cur));
        e = model(40, 20, 8, 8, PINK, 1'b0);
        exp_q.push_back(e);
        send_frame(40, 20, 8, 8, PINK, -1, -1);
        wait_report(to);
        e = exp_q.pop_front();
        checks++;
        if (to) begin
            failures++;
            $display("FAIL short_next no frame_done, required report %s", fmt(e));
        end else begin
            got = got_q.pop_front();
            if (got !== e) begin
                failures++;
                $display("FAIL short_next got %s required %s", fmt(got), fmt(e));
            end else begin
                $display("short_next report %s", fmt(got));
            end
        end
        last_exp = e;
    endtask

    task automatic test_reset_mid_frame;
        int   d0;
        rep_t e, got;
        bit   to;
        send_frame(10, 5, 8, 8, PINK, -1, 10);
        @(negedge clk);
        #2 sys_rst = 1'b1;
        #1;
        checks++;
        if (cur !== rep_t'(0) || frame_done !== 1'b0) begin
            failures++;
            $display("FAIL async_reset got %s done=%b required all zero", fmt(cur), frame_done);
        end
        $display("async_reset outputs %s", fmt(cur));
        repeat (2) @(negedge clk);
        sys_rst = 1'b0;
        got_q.delete();
        d0 = done_cnt;
        for (int i = 0; i < 2; i++) begin
            e = model(20 + i * 5, 30 - i * 10, 5, 6, PINK, 1'b0);
            exp_q.push_back(e);
            send_frame(20 + i * 5, 30 - i * 10, 5, 6, PINK, -1, -1);
            wait_report(to);
            e = exp_q.pop_front();
            checks++;
            if (to) begin
                failures++;
                $display("FAIL rst_frame_%0d no frame_done, required report %s", i, fmt(e));
            end else begin
                got = got_q.pop_front();
                if (got !== e) begin
                    failures++;
                    $display("FAIL rst_frame_%0d got %s required %s", i, fmt(got), fmt(e));
                end else begin
                    $display("rst_frame_%0d report %s", i, fmt(got));
                end
            end
        end
        repeat (20) @(negedge clk);
        checks++;
        if (done_cnt - d0 != 2) begin
            failures++;
            $display("FAIL rst_done_pulses got %0d required 2", done_cnt - d0);
        end
    endtask

    initial begin
        test_reset();
        test_frames("basic", 1, '{10, 0, 0, 0}, '{5, 0, 0, 0}, '{8, 0, 0, 0}, '{8, 0, 0, 0},
                    '{PINK, WHITE, WHITE, WHITE}, '{-1, -1, -1, -1});
        test_frames("tolerance", 2, '{10, 10, 0, 0}, '{5, 5, 0, 0}, '{8, 8, 0, 0}, '{8, 8, 0, 0},
                    '{24'hf8c8c4, 24'hf6c0cb, WHITE, WHITE}, '{-1, -1, -1, -1});
        test_frames("min_pixels", 2, '{30, 60, 0, 0}, '{30, 44, 0, 0}, '{3, 4, 0, 0}, '{3, 4, 0, 0},
                    '{PINK, PINK, WHITE, WHITE}, '{-1, -1, -1, -1});
        test_frames("fmt_err", 2, '{10, 10, 0, 0}, '{5, 5, 0, 0}, '{8, 8, 0, 0}, '{8, 8, 0, 0},
                    '{PINK, PINK, WHITE, WHITE}, '{20, -1, -1, -1});
        test_short_frame();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
